// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin broadcast bus scheduler.
// The destination ID is the top byte of every packet header.
package bus_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        ROUTE,
        PUSH
    } state_t;

    localparam int ID_W = 8;
    localparam int PKT_MAX_W = 256;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

    // Packets are zero-extended to PKT_MAX_W so one helper serves any packet width.
    function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                 input int pckgSz);
        return ID_W'(pkt >> (pckgSz - ID_W));
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Driver-FIFO pop side and destination push side of the shared bus.
// The master modport is the scheduler, the slave modport is the FIFO array.
interface bus_rr_scheduler_if #(
    parameter int PCKG_SZ = 16,
    parameter int DRVRS   = 8
);
    logic [DRVRS-1:0]              pndng;
    logic [DRVRS-1:0][PCKG_SZ-1:0] d_pop;
    logic [DRVRS-1:0]              pop;
    logic [DRVRS-1:0]              full;
    logic [DRVRS-1:0]              push;
    logic [PCKG_SZ-1:0]            d_push;

    modport master (
        input  pndng, d_pop, full,
        output pop, push, d_push
    );

    modport slave (
        output pndng, d_pop, full,
        input  pop, push, d_push
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', with wrap.
// Searching offsets 1..DRVRS puts the previous winner last in line.
module rr_pick
    import bus_sched_pkg::*;
#(
    parameter int DRVRS = 8
) (
    input  logic [DRVRS-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [ID_W-1:0]  gnt_idx_o,
    output logic             any_o
);

    logic found;
    int   cand;

    always_comb begin
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 1; k <= DRVRS; k++) begin
            cand = (int'(last_i) + k) % DRVRS;
            if (!found && |(req_i & (DRVRS'(1) << cand))) begin
                found     = 1'b1;
                gnt_idx_o = ID_W'(cand);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler for the shared broadcast bus: grant, pop, decode the
// destination, then push once every addressed destination has room.
module bus_rr_scheduler
    import bus_sched_pkg::*;
#(
    parameter int              PCKG_SZ   = 16,
    parameter int              DRVRS     = 8,
    parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID
) (
    input  logic                   clk,
    input  logic                   rst,
    bus_rr_scheduler_if.master     bus,
    output logic                   busy_o,
    output logic [ID_W-1:0]        grant_id_o,
    output logic [15:0]            pkt_cnt_o,
    output logic [ID_W-1:0]        drop_cnt_o
);

    localparam int IDX_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;
    localparam logic [DRVRS-1:0] ALL_ONES = '1;

    state_t             state_q;
    logic [ID_W-1:0]    grant_q;
    logic [ID_W-1:0]    last_q;
    logic [PCKG_SZ-1:0] pkt_q;
    logic [DRVRS-1:0]   mask_q;
    logic [DRVRS-1:0]   pop_q;
    logic [DRVRS-1:0]   push_q;
    logic [PCKG_SZ-1:0] dpush_q;
    logic [15:0]        pkt_cnt_q;
    logic [ID_W-1:0]    drop_cnt_q;

    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic [DRVRS-1:0]   grant_oh;
    logic               pndng_g;
    logic [ID_W-1:0]    dest;
    logic               is_bcast;
    logic               dest_ok;
    logic [DRVRS-1:0]   route_mask;

    rr_pick #(
        .DRVRS (DRVRS)
    ) u_rr_pick (
        .req_i     (bus.pndng),
        .last_i    (last_q),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    assign grant_oh   = DRVRS'(1) << grant_q;
    assign pndng_g    = |(bus.pndng & grant_oh);
    assign dest       = dest_of(PKT_MAX_W'(pkt_q), PCKG_SZ);
    assign is_bcast   = (dest == BROADCAST);
    assign dest_ok    = (32'(dest) < DRVRS);
    assign route_mask = is_bcast ? (ALL_ONES & ~grant_oh) : (DRVRS'(1) << dest);

    // In PUSH, push_q==0 means still waiting on backpressure; nonzero means the
    // single delivery cycle is on the bus and the packet completes at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= ID_W'(DRVRS - 1);
            pkt_q      <= '0;
            mask_q     <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            dpush_q    <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        pop_q   <= DRVRS'(1) << pick_idx;
                        state_q <= POP;
                    end
                end
                POP: begin
                    pop_q <= '0;
                    if (pndng_g) begin
                        pkt_q   <= bus.d_pop[grant_q[IDX_W-1:0]];
                        state_q <= ROUTE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ROUTE: begin
                    if (is_bcast || dest_ok) begin
                        mask_q  <= route_mask;
                        state_q <= PUSH;
                        if ((route_mask & bus.full) == '0) begin
                            push_q  <= route_mask;
                            dpush_q <= pkt_q;
                        end
                    end else begin
                        if (drop_cnt_q != '1) begin
                            drop_cnt_q <= drop_cnt_q + 1'b1;
                        end
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                PUSH: begin
                    if (push_q != '0) begin
                        push_q <= '0;
                        if (pkt_cnt_q != '1) begin
                            pkt_cnt_q <= pkt_cnt_q + 1'b1;
                        end
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end else if ((mask_q & bus.full) == '0) begin
                        push_q  <= mask_q;
                        dpush_q <= pkt_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pop    = pop_q;
    assign bus.push   = push_q;
    assign bus.d_push = dpush_q;
    assign busy_o     = (state_q != IDLE);
    assign grant_id_o = grant_q;
    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: FIFO model on the pop side and a
// scoreboard monitor that matches every push against queued expectations.
module tb_bus_rr_scheduler;
    import bus_sched_pkg::*;

    localparam int DRVRS   = 8;
    localparam int PCKG_SZ = 16;

    typedef struct packed {
        logic [7:0]  mask;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [7:0]  grantId;
    logic [15:0] pktCnt;
    logic [7:0]  dropCnt;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t monExp;
    logic [15:0] fifoQ[DRVRS][$];
    logic [DRVRS-1:0] popSnap;

    bus_rr_scheduler_if #(.PCKG_SZ(PCKG_SZ), .DRVRS(DRVRS)) busIf();

    bus_rr_scheduler #(
        .PCKG_SZ   (PCKG_SZ),
        .DRVRS     (DRVRS),
        .BROADCAST (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (busIf),
        .busy_o     (busy),
        .grant_id_o (grantId),
        .pkt_cnt_o  (pktCnt),
        .drop_cnt_o (dropCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic refresh();
        logic [DRVRS-1:0]        p;
        logic [DRVRS-1:0][15:0]  h;
        p = '0;
        h = '0;
        for (int d = 0; d < DRVRS; d++) begin
            if (fifoQ[d].size() > 0) begin
                p[d] = 1'b1;
                h[d] = fifoQ[d][0];
            end
        end
        busIf.pndng = p;
        busIf.d_pop = h;
    endtask

    // One clock: pops seen during the cycle retire FIFO heads just after the edge.
    task automatic step();
        @(negedge clk);
        popSnap = busIf.pop;
        @(posedge clk);
        #1;
        for (int d = 0; d < DRVRS; d++) begin
            if (popSnap[d] && fifoQ[d].size() > 0) begin
                void'(fifoQ[d].pop_front());
            end
        end
        refresh();
    endtask

    function automatic logic fifosEmpty();
        logic e;
        e = 1'b1;
        for (int d = 0; d < DRVRS; d++) begin
            if (fifoQ[d].size() > 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic applyStimulus(input int drv, input logic [15:0] pkt);
        fifoQ[drv].push_back(pkt);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while (k < budget && !(busy == 1'b0 && fifosEmpty())) begin
            step();
            k++;
        end
        checkOutput("idleReached", {31'b0, (busy == 1'b0 && fifosEmpty())}, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && busIf.push != '0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPush", {24'b0, busIf.push}, 0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("pushMask", {24'b0, busIf.push}, {24'b0, monExp.mask});
                checkOutput("pushData", {16'b0, busIf.d_push}, {16'b0, monExp.data});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int seen;
        busIf.full = '0;
        refresh();
        #12;
        checkOutput("rstPop", busIf.pop, 0);
        checkOutput("rstPush", busIf.push, 0);
        checkOutput("rstDPush", busIf.d_push, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstGrant", grantId, 0);
        checkOutput("rstPktCnt", pktCnt, 0);
        checkOutput("rstDropCnt", dropCnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single packet");
        applyStimulus(2, 16'h05AB);
        expQ.push_back({8'h20, 16'h05AB});
        step();
        checkOutput("t1Idle", busy, 0);
        step();
        checkOutput("t1Pop", busIf.pop, 8'h04);
        checkOutput("t1Grant", grantId, 2);
        step();
        checkOutput("t1RoutePop", busIf.pop, 0);
        checkOutput("t1RoutePush", busIf.push, 0);
        step();
        checkOutput("t1Push", busIf.push, 8'h20);
        checkOutput("t1Data", busIf.d_push, 16'h05AB);
        step();
        checkOutput("t1Busy", busy, 0);
        checkOutput("t1PktCnt", pktCnt, 1);
        checkOutput("t1PushDrop", busIf.push, 0);
        checkOutput("t1DataHold", busIf.d_push, 16'h05AB);

        $display("[TB] round robin");
        applyReset();
        for (int n = 0; n < 2; n++) begin
            for (int d = 0; d < DRVRS; d++) begin
                applyStimulus(d, {8'h00, 4'(d), 4'(n)});
                expQ.push_back({8'h01, 8'h00, 4'(d), 4'(n)});
            end
        end
        seen = 0;
        for (int k = 0; k < 300 && seen < 16; k++) begin
            step();
            if (busIf.pop != '0) begin
                checkOutput("t2Grant", grantId, seen % DRVRS);
                checkOutput("t2Pop", busIf.pop, 32'd1 << (seen % DRVRS));
                seen++;
            end
        end
        checkOutput("t2Grants", seen, 16);
        waitIdle(50);
        checkOutput("t2PktCnt", pktCnt, 16);

        $display("[TB] broadcast");
        applyStimulus(3, 16'hFF12);
        expQ.push_back({8'hF7, 16'hFF12});
        waitIdle(20);
        checkOutput("t3PktCnt", pktCnt, 17);

        $display("[TB] invalid destination");
        applyStimulus(1, 16'h09CD);
        step();
        step();
        step();
        checkOutput("t4RouteBusy", busy, 1);
        step();
        checkOutput("t4Idle", busy, 0);
        checkOutput("t4DropCnt", dropCnt, 1);
        checkOutput("t4PktCnt", pktCnt, 17);

        $display("[TB] backpressure");
        applyReset();
        busIf.full = 8'h10;
        applyStimulus(0, 16'h0411);
        applyStimulus(5, 16'h0022);
        expQ.push_back({8'h10, 16'h0411});
        expQ.push_back({8'h01, 16'h0022});
        step();
        step();
        checkOutput("t5Pop", busIf.pop, 8'h01);
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            checkOutput("t5Stall", {busIf.push, busIf.pop}, 0);
            checkOutput("t5StallBusy", busy, 1);
        end
        busIf.full = 8'h00;
        step();
        checkOutput("t5Push", busIf.push, 8'h10);
        checkOutput("t5Data", busIf.d_push, 16'h0411);
        waitIdle(30);
        checkOutput("t5PktCnt", pktCnt, 2);

        $display("[TB] reset during push");
        applyReset();
        busIf.full = 8'h10;
        applyStimulus(6, 16'h0433);
        step();
        step();
        step();
        step();
        checkOutput("t6Waiting", {busy, busIf.push}, 9'h100);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6Pop", busIf.pop, 0);
        checkOutput("t6Push", busIf.push, 0);
        checkOutput("t6DPush", busIf.d_push, 0);
        checkOutput("t6Busy", busy, 0);
        checkOutput("t6Grant", grantId, 0);
        checkOutput("t6PktCnt", pktCnt, 0);
        busIf.full = 8'h00;
        for (int d = 0; d < DRVRS; d++) begin
            applyStimulus(d, {8'h00, 8'h80 + 8'(d)});
            expQ.push_back({8'h01, 8'h00, 8'h80 + 8'(d)});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            step();
            if (busIf.pop != '0) begin
                checkOutput("t6FirstPop", busIf.pop, 8'h01);
                seen = 1;
            end
        end
        checkOutput("t6PopSeen", seen, 1);
        waitIdle(60);
        checkOutput("t6PktCnt2", pktCnt, 8);

        step();
        checkOutput("expQEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
